// File: rtl/pipe_scheduler_pkg.sv
// Shared graphics package for the frame scheduler: FSM state encoding,
// the default watchdog limit and the vertex-pipe exit latency.
package pipe_scheduler_pkg;

    localparam int unsigned WATCHDOG_CYCLES_DEF = 1048576;

    // pipe_done is stale for this many cycles after a pipe_start
    localparam logic [1:0] PIPE_EXIT_LAT = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        LATCH,
        MVP_START,
        MVP_WAIT,
        XF_START,
        XF_WAIT,
        RS_START,
        RS_WAIT,
        SWAP
    } sched_state_t;

endpackage

// File: rtl/sched_watchdog.sv
// Cycle counter for the scheduler wait states; cleared whenever enable is low,
// expired flags the last permitted cycle so the FSM aborts on that edge.
module sched_watchdog
    import pipe_scheduler_pkg::*;
#(
    parameter int unsigned CYCLES = WATCHDOG_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(CYCLES - 1));

endmodule

// File: rtl/pipe_scheduler.sv
// Frame scheduler: latches pose, drives the vertex pipe (MVP then transform),
// the rasterizer, and swaps framebuffers. Watchdog enabled by PIPE_SCHED_WATCHDOG_EN.
module pipe_scheduler
    import pipe_scheduler_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEF,
    parameter int unsigned FRAME_CNT_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   frame_req,
    input  logic [31:0]            roll,
    input  logic [31:0]            pitch,
    input  logic [31:0]            yaw,
    input  logic [31:0]            x,
    input  logic [31:0]            y,
    input  logic [31:0]            z,
    input  logic [31:0]            vertex_count,
    output logic [31:0]            pipe_roll,
    output logic [31:0]            pipe_pitch,
    output logic [31:0]            pipe_yaw,
    output logic [31:0]            pipe_x,
    output logic [31:0]            pipe_y,
    output logic [31:0]            pipe_z,
    output logic [31:0]            pipe_count,
    output logic                   pipe_start,
    output logic                   pipe_update_mvp,
    input  logic                   pipe_done,
    output logic                   raster_start,
    input  logic                   raster_done,
    output logic                   buf_sel,
    output logic                   busy,
    output logic                   frame_drop,
    output logic                   error,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    sched_state_t state;
    logic         pending;
    logic [1:0]   exit_cnt;
    logic         wd_expired;

`ifdef PIPE_SCHED_WATCHDOG_EN
    logic in_wait;
    assign in_wait = (state == MVP_WAIT) || (state == XF_WAIT) || (state == RS_WAIT);

    sched_watchdog #(.CYCLES(WATCHDOG_CYCLES)) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (in_wait),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else if (wd_expired) begin
            error <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign error      = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            pending         <= 1'b0;
            exit_cnt        <= '0;
            pipe_roll       <= '0;
            pipe_pitch      <= '0;
            pipe_yaw        <= '0;
            pipe_x          <= '0;
            pipe_y          <= '0;
            pipe_z          <= '0;
            pipe_count      <= '0;
            pipe_start      <= 1'b0;
            pipe_update_mvp <= 1'b0;
            raster_start    <= 1'b0;
            buf_sel         <= 1'b0;
            busy            <= 1'b0;
            frame_drop      <= 1'b0;
            frame_count     <= '0;
        end else begin
            frame_drop <= 1'b0;
            // A request arriving on the SWAP edge lands here too, so it is kept
            if (frame_req && (state != IDLE)) begin
                if (pending) begin
                    frame_drop <= 1'b1;
                end
                pending <= 1'b1;
            end

            if (wd_expired) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_req || pending) begin
                            pending <= 1'b0;
                            busy    <= 1'b1;
                            state   <= LATCH;
                        end
                    end
                    LATCH: begin
                        pipe_roll       <= roll;
                        pipe_pitch      <= pitch;
                        pipe_yaw        <= yaw;
                        pipe_x          <= x;
                        pipe_y          <= y;
                        pipe_z          <= z;
                        pipe_count      <= vertex_count;
                        pipe_start      <= 1'b1;
                        pipe_update_mvp <= 1'b1;
                        state           <= MVP_START;
                    end
                    MVP_START: begin
                        pipe_start      <= 1'b0;
                        pipe_update_mvp <= 1'b0;
                        exit_cnt        <= '0;
                        state           <= MVP_WAIT;
                    end
                    MVP_WAIT: begin
                        if (exit_cnt < PIPE_EXIT_LAT) begin
                            exit_cnt <= exit_cnt + 2'd1;
                        end else if (pipe_done) begin
                            if (pipe_count == '0) begin
                                state <= SWAP;
                            end else begin
                                pipe_start <= 1'b1;
                                state      <= XF_START;
                            end
                        end
                    end
                    XF_START: begin
                        pipe_start <= 1'b0;
                        exit_cnt   <= '0;
                        state      <= XF_WAIT;
                    end
                    XF_WAIT: begin
                        if (exit_cnt < PIPE_EXIT_LAT) begin
                            exit_cnt <= exit_cnt + 2'd1;
                        end else if (pipe_done) begin
                            raster_start <= 1'b1;
                            state        <= RS_START;
                        end
                    end
                    RS_START: begin
                        raster_start <= 1'b0;
                        state        <= RS_WAIT;
                    end
                    RS_WAIT: begin
                        if (raster_done) begin
                            state <= SWAP;
                        end
                    end
                    SWAP: begin
                        buf_sel     <= ~buf_sel;
                        frame_count <= frame_count + FRAME_CNT_W'(1);
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler with a scoreboard of expected pipe_start
// commands and frame completions; behavioural vertex-pipe and rasterizer models.
module tb_pipe_scheduler;

    localparam int unsigned FCW = 4;
    localparam int unsigned WD  = 64;

    logic           clock = 1'b0;
    logic           reset_n = 1'b1;
    logic           frame_req = 1'b0;
    logic [31:0]    roll = '0, pitch = '0, yaw = '0, x = '0, y = '0, z = '0;
    logic [31:0]    vertex_count = '0;
    logic [31:0]    pipe_roll, pipe_pitch, pipe_yaw, pipe_x, pipe_y, pipe_z, pipe_count;
    logic           pipe_start, pipe_update_mvp, raster_start;
    logic           pipe_done = 1'b1;
    logic           raster_done = 1'b0;
    logic           buf_sel, busy, frame_drop, error;
    logic [FCW-1:0] frame_count;

    pipe_scheduler #(.WATCHDOG_CYCLES(WD), .FRAME_CNT_W(FCW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .frame_req       (frame_req),
        .roll            (roll),
        .pitch           (pitch),
        .yaw             (yaw),
        .x               (x),
        .y               (y),
        .z               (z),
        .vertex_count    (vertex_count),
        .pipe_roll       (pipe_roll),
        .pipe_pitch      (pipe_pitch),
        .pipe_yaw        (pipe_yaw),
        .pipe_x          (pipe_x),
        .pipe_y          (pipe_y),
        .pipe_z          (pipe_z),
        .pipe_count      (pipe_count),
        .pipe_start      (pipe_start),
        .pipe_update_mvp (pipe_update_mvp),
        .pipe_done       (pipe_done),
        .raster_start    (raster_start),
        .raster_done     (raster_done),
        .buf_sel         (buf_sel),
        .busy            (busy),
        .frame_drop      (frame_drop),
        .error           (error),
        .frame_count     (frame_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mvp;
        logic [31:0] cnt;
        logic [31:0] xv;
    } pexp_t;

    typedef struct {
        logic [FCW-1:0] fc;
        logic           bs;
    } fexp_t;

    pexp_t pq[$];
    fexp_t fq[$];
    pexp_t pe;
    fexp_t fe;

    int             exp_fc = 0;
    logic           exp_bs = 1'b0;
    int             n_ps = 0, n_rs = 0, n_drop = 0;
    logic [FCW-1:0] fc_prev = '0;
    int             pipe_busy_cnt = 0;
    int             rcnt = 0;
    logic           raster_en = 1'b1;
    logic           raster_kick = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Vertex pipe: done drops for 5 cycles after each start strobe
    always @(negedge clock) begin
        if (pipe_start) begin
            pipe_done     = 1'b0;
            pipe_busy_cnt = 5;
        end else if (pipe_busy_cnt > 0) begin
            pipe_busy_cnt--;
            if (pipe_busy_cnt == 0) pipe_done = 1'b1;
        end
    end

    // Rasterizer: one-cycle done pulse 10 cycles after start
    always @(negedge clock) begin
        raster_done = 1'b0;
        if (raster_kick) begin
            raster_kick = 1'b0;
            raster_done = 1'b1;
        end else if (raster_start) begin
            if (raster_en) rcnt = 10;
        end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) raster_done = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            fc_prev = '0;
        end else begin
            if (pipe_start) begin
                n_ps++;
                if (pq.size() == 0) begin
                    chk("pipe_start_extra", 32'(pipe_start), 32'd0);
                end else begin
                    pe = pq.pop_front();
                    chk("pipe_update_mvp", 32'(pipe_update_mvp), 32'(pe.mvp));
                    chk("pipe_count", pipe_count, pe.cnt);
                    chk("pipe_x", pipe_x, pe.xv);
                end
            end
            if (raster_start) n_rs++;
            if (frame_drop) n_drop++;
            if (frame_count !== fc_prev) begin
                if (fq.size() == 0) begin
                    chk("frame_count_extra", 32'(frame_count), 32'(fc_prev));
                end else begin
                    fe = fq.pop_front();
                    chk("frame_count", 32'(frame_count), 32'(fe.fc));
                    chk("buf_sel", 32'(buf_sel), 32'(fe.bs));
                end
                fc_prev = frame_count;
            end
        end
    end

    task automatic set_pose(input logic [31:0] cnt, input logic [31:0] xv);
        vertex_count = cnt;
        x     = xv;
        roll  = xv ^ 32'hA5A5_A5A5;
        pitch = xv + 32'd1;
        yaw   = xv + 32'd2;
        y     = xv + 32'd3;
        z     = xv + 32'd4;
    endtask

    task automatic expect_pipe(input logic [31:0] cnt, input logic [31:0] xv);
        pq.push_back('{mvp: 1'b1, cnt: cnt, xv: xv});
        if (cnt != 0) pq.push_back('{mvp: 1'b0, cnt: cnt, xv: xv});
    endtask

    task automatic expect_frame();
        exp_fc = (exp_fc + 1) % (1 << FCW);
        exp_bs = ~exp_bs;
        fq.push_back('{fc: FCW'(exp_fc), bs: exp_bs});
    endtask

    task automatic req_pulse();
        @(posedge clock); #1 frame_req = 1'b1;
        @(posedge clock); #1 frame_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i = 0;
        while (i < budget && (busy || fq.size() != 0 || pq.size() != 0)) begin
            @(negedge clock);
            i++;
        end
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frames_left"}, 32'(fq.size()), 32'd0);
    endtask

    task automatic wait_raster_start(input string tag);
        int base = n_rs;
        for (int i = 0; i < 200 && n_rs == base; i++) @(negedge clock);
        chk(tag, 32'(n_rs - base), 32'd1);
    endtask

    initial begin
        int ps0, rs0, dr0, ncyc;

        // Reset state
        #3 reset_n = 1'b0;
        #10;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pipe_start", 32'(pipe_start), 32'd0);
        chk("rst_raster_start", 32'(raster_start), 32'd0);
        chk("rst_buf_sel", 32'(buf_sel), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_pipe_x", pipe_x, 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Nominal frame; x input changes after LATCH must not reach pipe_x
        ps0 = n_ps; rs0 = n_rs;
        set_pose(32'd3, 32'h3F80_0000);
        expect_pipe(32'd3, 32'h3F80_0000);
        expect_frame();
        req_pulse();
        chk("nom_busy_after_req", 32'(busy), 32'd1);
        repeat (3) @(negedge clock);
        chk("nom_pipe_roll", pipe_roll, 32'h3F80_0000 ^ 32'hA5A5_A5A5);
        set_pose(32'd7, 32'hDEAD_BEEF);
        wait_done(300, "nom");
        chk("nom_pipe_starts", 32'(n_ps - ps0), 32'd2);
        chk("nom_raster_starts", 32'(n_rs - rs0), 32'd1);
        chk("nom_buf_sel", 32'(buf_sel), 32'd1);
        chk("nom_frame_count", 32'(frame_count), 32'd1);

        // Reset during XF_WAIT
        ps0 = n_ps;
        set_pose(32'd2, 32'h4000_0000);
        expect_pipe(32'd2, 32'h4000_0000);
        expect_frame();
        req_pulse();
        for (int i = 0; i < 100 && (n_ps - ps0) < 2; i++) @(negedge clock);
        chk("mid_reach_xf", 32'(n_ps - ps0), 32'd2);
        @(posedge clock); @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_buf_sel", 32'(buf_sel), 32'd0);
        chk("mid_frame_count", 32'(frame_count), 32'd0);
        chk("mid_pipe_x", pipe_x, 32'd0);
        chk("mid_pipe_count", pipe_count, 32'd0);
        chk("mid_strobes", {29'd0, pipe_start, pipe_update_mvp, raster_start}, 32'd0);
        pq.delete();
        fq.delete();
        exp_fc = 0;
        exp_bs = 1'b0;
        @(posedge clock); @(posedge clock);
        #1 reset_n = 1'b1;
        ps0 = n_ps;
        repeat (6) @(negedge clock);
        chk("mid_no_replay", 32'(n_ps - ps0), 32'd0);
        chk("mid_idle", 32'(busy), 32'd0);
        set_pose(32'd1, 32'h4040_0000);
        expect_pipe(32'd1, 32'h4040_0000);
        expect_frame();
        req_pulse();
        wait_done(300, "mid_restart");
        chk("mid_restart_fc", 32'(frame_count), 32'd1);

        // Zero vertex count skips transform and raster
        ps0 = n_ps; rs0 = n_rs;
        set_pose(32'd0, 32'h1234_5678);
        expect_pipe(32'd0, 32'h1234_5678);
        expect_frame();
        req_pulse();
        wait_done(200, "zero");
        chk("zero_pipe_starts", 32'(n_ps - ps0), 32'd1);
        chk("zero_raster_starts", 32'(n_rs - rs0), 32'd0);
        chk("zero_buf_sel", 32'(buf_sel), 32'(exp_bs));

        // Overload: three requests during RS_WAIT
        ps0 = n_ps; rs0 = n_rs; dr0 = n_drop;
        set_pose(32'd2, 32'h0000_00A1);
        expect_pipe(32'd2, 32'h0000_00A1);
        expect_frame();
        req_pulse();
        wait_raster_start("ovl_raster_start");
        set_pose(32'd1, 32'h0000_00B2);
        expect_pipe(32'd1, 32'h0000_00B2);
        expect_frame();
        req_pulse();
        req_pulse();
        req_pulse();
        wait_done(400, "ovl");
        chk("ovl_drops", 32'(n_drop - dr0), 32'd2);
        chk("ovl_pipe_starts", 32'(n_ps - ps0), 32'd4);
        chk("ovl_raster_starts", 32'(n_rs - rs0), 32'd2);
        chk("ovl_frame_count", 32'(frame_count), 32'(exp_fc));

        // Request on the SWAP-to-IDLE edge becomes pending, not dropped
        dr0 = n_drop;
        set_pose(32'd1, 32'h0000_00C3);
        expect_pipe(32'd1, 32'h0000_00C3);
        expect_frame();
        req_pulse();
        ncyc = 0;
        while (ncyc < 200 && !raster_done) begin
            @(posedge clock);
            ncyc++;
        end
        chk("swap_seen_raster_done", 32'(raster_done), 32'd1);
        #1;
        set_pose(32'd0, 32'h0000_00D4);
        expect_pipe(32'd0, 32'h0000_00D4);
        expect_frame();
        frame_req = 1'b1;
        @(posedge clock); #1 frame_req = 1'b0;
        wait_done(300, "swapreq");
        chk("swapreq_drops", 32'(n_drop - dr0), 32'd0);
        chk("swapreq_frame_count", 32'(frame_count), 32'(exp_fc));

        // frame_count wraps at 2^FCW
        ncyc = (1 << FCW) - exp_fc;
        for (int i = 0; i < ncyc; i++) begin
            set_pose(32'd0, 32'(i));
            expect_pipe(32'd0, 32'(i));
            expect_frame();
            req_pulse();
            wait_done(100, "wrap");
        end
        chk("wrap_frame_count_zero", 32'(frame_count), 32'd0);

        // Rasterizer never answers
        raster_en = 1'b0;
        set_pose(32'd1, 32'h0000_00E5);
        expect_pipe(32'd1, 32'h0000_00E5);
        req_pulse();
        wait_raster_start("wd_raster_start");
        ncyc = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            @(negedge clock);
            ncyc++;
        end
`ifdef PIPE_SCHED_WATCHDOG_EN
        // 64 cycles in RS_WAIT, plus the negedge that falls in RS_START
        chk("wd_abort_cycles", 32'(ncyc), 32'(WD + 1));
        chk("wd_error", 32'(error), 32'd1);
        chk("wd_buf_sel", 32'(buf_sel), 32'(exp_bs));
        chk("wd_frame_count", 32'(frame_count), 32'(exp_fc));
        repeat (4) @(negedge clock);
        chk("wd_stays_idle", 32'(busy), 32'd0);
        raster_en = 1'b1;
        set_pose(32'd1, 32'h0000_00F6);
        expect_pipe(32'd1, 32'h0000_00F6);
        expect_frame();
        req_pulse();
        wait_done(300, "wd_next");
        chk("wd_error_sticky", 32'(error), 32'd1);
        @(posedge clock); #1 reset_n = 1'b0;
        #1;
        chk("wd_error_reset", 32'(error), 32'd0);
        @(posedge clock); #1 reset_n = 1'b1;
`else
        chk("nowd_still_waiting", 32'(busy), 32'd1);
        chk("nowd_error", 32'(error), 32'd0);
        chk("nowd_frame_count", 32'(frame_count), 32'(exp_fc));
        raster_en = 1'b1;
        expect_frame();
        raster_kick = 1'b1;
        wait_done(100, "nowd_finish");
        chk("nowd_error_after", 32'(error), 32'd0);
`endif

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
